multicycle_controller: RTL

//  Multicycle RV32I control FSM; sits upstream of the immediate extender and the datapath muxes.

---
 rtl/multicycle_controller_pkg.sv | 69 ++++++
 rtl/multicycle_controller_if.sv | 31 +++
 rtl/multicycle_controller_alu_decoder.sv | 29 ++
 rtl/multicycle_controller.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - riscv_ctrl_pkg: opcodes, select encodings, states, aluOp type
// TRAP state exists only when ILLEGAL_OP_TRAP_EN is defined.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_t;

  typedef logic [3:0] state_t;
  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECR    = 4'd6;
  localparam state_t S_EXECI    = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;
  localparam state_t S_JAL      = 4'd10;
  localparam state_t S_JALR     = 4'd11;
  localparam state_t S_JALRPC   = 4'd12;
  localparam state_t S_LUI      = 4'd13;
`ifdef ILLEGAL_OP_TRAP_EN
  localparam state_t S_TRAP     = 4'd14;
`endif

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_LUI:    return IMM_U;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - decode inputs and control outputs between controller and datapath
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       lt;
  logic [2:0] immSrc;
  logic [2:0] aluControl;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] resultSrc;
  logic       adrSrc;
  logic       irWrite;
  logic       pcWrite;
  logic       memWrite;
  logic       regWrite;
  logic       illegalOp;

  modport master (
    input  op, funct3, funct7b5, zero, lt,
    output immSrc, aluControl, aluSrcA, aluSrcB, resultSrc, adrSrc,
    output irWrite, pcWrite, memWrite, regWrite, illegalOp
  );

  modport slave (
    output op, funct3, funct7b5, zero, lt,
    input  immSrc, aluControl, aluSrcA, aluSrcB, resultSrc, adrSrc,
    input  irWrite, pcWrite, memWrite, regWrite, illegalOp
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// rtl/multicycle_controller_alu_decoder.sv - alu_decoder: aluOp/funct fields to aluControl
// op5 separates R-type from I-ALU so that immediates never select sub.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t    alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control_o = ALU_AND;
          3'b110:  alu_control_o = ALU_OR;
          3'b010:  alu_control_o = ALU_SLT;
          3'b100:  alu_control_o = ALU_XOR;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM with MEM_LAT wait counter
// ILLEGAL_OP_TRAP_EN adds a sticky TRAP state for unknown opcodes.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_controller_if.master ctrl
);
  localparam logic [1:0] CNT_LAST = 2'(MEM_LAT - 1);

  state_t     state_q, state_d, state_eff;
  logic [1:0] cnt_q, cnt_d;
  logic       cnt_last, taken;
  alu_op_t    alu_op;
  logic [1:0] src_a, src_b, res_src;
  logic       adr_src, ir_wr, pc_wr, mem_wr, reg_wr;

  assign cnt_last  = (cnt_q == CNT_LAST);
  // Outputs look like FETCH during reset regardless of the held state.
  assign state_eff = rst ? S_FETCH : state_q;

  always_comb begin
    case (ctrl.funct3)
      3'b000:  taken = ctrl.zero;
      3'b001:  taken = ~ctrl.zero;
      3'b100:  taken = ctrl.lt;
      3'b101:  taken = ~ctrl.lt;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (cnt_last) state_d = S_DECODE;
      S_DECODE: begin
        case (ctrl.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
`ifdef ILLEGAL_OP_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:  state_d = (ctrl.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: if (cnt_last) state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_JALR:    state_d = S_JALRPC;
      S_JALRPC:  state_d = S_ALUWB;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:    state_d = S_TRAP;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  // Counter restarts on every state change, so entry into FETCH/MEMREAD sees 0.
  assign cnt_d = (state_d != state_q) ? 2'd0 : (cnt_last ? cnt_q : cnt_q + 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic ill_q;
  always_ff @(posedge clk) begin
    if (rst) ill_q <= 1'b0;
    else if (state_d == S_TRAP) ill_q <= 1'b1;
  end
  assign ctrl.illegalOp = ill_q;
`else
  assign ctrl.illegalOp = 1'b0;
`endif

  always_comb begin
    src_a   = SRCA_PC;
    src_b   = SRCB_RS2;
    res_src = RES_ALUOUT;
    adr_src = 1'b0;
    alu_op  = ALUOP_ADD;
    ir_wr   = 1'b0;
    pc_wr   = 1'b0;
    mem_wr  = 1'b0;
    reg_wr  = 1'b0;
    case (state_eff)
      S_FETCH: begin
        src_b   = SRCB_FOUR;
        res_src = RES_ALURESULT;
        ir_wr   = cnt_last;
        pc_wr   = cnt_last;
      end
      S_DECODE:   begin src_a = SRCA_OLDPC; src_b = SRCB_IMM; end
      S_MEMADR:   begin src_a = SRCA_RS1; src_b = SRCB_IMM; end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB:    begin res_src = RES_MEMDATA; reg_wr = 1'b1; end
      S_MEMWRITE: begin adr_src = 1'b1; mem_wr = 1'b1; end
      S_EXECR:    begin src_a = SRCA_RS1; alu_op = ALUOP_FUNCT; end
      S_EXECI:    begin src_a = SRCA_RS1; src_b = SRCB_IMM; alu_op = ALUOP_FUNCT; end
      S_ALUWB:    reg_wr = 1'b1;
      S_BRANCH:   begin src_a = SRCA_RS1; alu_op = ALUOP_SUB; pc_wr = taken; end
      S_JAL, S_JALRPC: begin src_a = SRCA_OLDPC; src_b = SRCB_FOUR; pc_wr = 1'b1; end
      S_JALR:     begin src_a = SRCA_RS1; src_b = SRCB_IMM; end
      S_LUI:      begin res_src = RES_IMMEXT; reg_wr = 1'b1; end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (ctrl.funct3),
    .funct7b5_i    (ctrl.funct7b5),
    .op5_i         (ctrl.op[5]),
    .alu_control_o (ctrl.aluControl)
  );

  assign ctrl.immSrc    = imm_sel(ctrl.op);
  assign ctrl.aluSrcA   = src_a;
  assign ctrl.aluSrcB   = src_b;
  assign ctrl.resultSrc = res_src;
  assign ctrl.adrSrc    = adr_src;
  assign ctrl.irWrite   = ir_wr  & ~rst;
  assign ctrl.pcWrite   = pc_wr  & ~rst;
  assign ctrl.memWrite  = mem_wr & ~rst;
  assign ctrl.regWrite  = reg_wr & ~rst;
endmodule
